instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 33 +++
 rtl/instr_fetch.sv | 103 ++++++++++
 tb/tb_instr_fetch.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared instruction-set definitions: opcode values, fetch FSM states and
// the instruction-length predicate used by memory, fetch and decode.
package instr_fetch_pkg;

  localparam int unsigned WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  // Opcode values that the fetch unit and decoder must agree on.
  localparam word_t OP_NOP   = 16'd0;
  localparam word_t OP_LDAC  = 16'd6;
  localparam word_t OP_STAC  = 16'd8;
  localparam word_t OP_JPNZ  = 16'd29;
  localparam word_t OP_JPPZ  = 16'd31;
  localparam word_t OP_ENDOP = 16'd43;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OP_WAIT,
    S_OP_CAP,
    S_ARG_CAP,
    S_ISSUE,
    S_HALT
  } fetch_state_t;

  // Opcodes followed by an operand word; anything else, including
  // undefined encodings, occupies a single word.
  function automatic logic is_two_word(input word_t op);
    return (op == OP_LDAC) || (op == OP_STAC) ||
           (op == OP_JPNZ) || (op == OP_JPPZ);
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads one- or two-word instructions from a
// registered-read instruction memory and presents them to the core over a
// valid/ready handshake, with branch redirect and halt on ENDOP.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [15:0] im_addr,
  input  logic [15:0] im_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr_opcode,
  output logic [15:0] instr_operand,
  output logic [15:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_addr,
  output logic        halted
);

  fetch_state_t state, state_nx;
  word_t        pc, pc_nx;
  word_t        pc_plus1;
  logic         redirect_live;

  assign pc_plus1 = pc + 16'd1;

  // Redirect only matters while a fetch sequence is in progress.
  assign redirect_live = redirect_valid &&
                         (state inside {S_OP_WAIT, S_OP_CAP, S_ARG_CAP, S_ISSUE});

  // State and program-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
    end
  end

  // Next-state and next-pc selection; redirect overrides any handshake.
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    case (state)
      S_IDLE:    if (start) state_nx = S_OP_WAIT;
      S_OP_WAIT: state_nx = S_OP_CAP;
      S_OP_CAP:  state_nx = is_two_word(im_data) ? S_ARG_CAP : S_ISSUE;
      S_ARG_CAP: state_nx = S_ISSUE;
      S_ISSUE: begin
        if (instr_ready) begin
          if (instr_opcode == OP_ENDOP) begin
            state_nx = S_HALT;
          end else begin
            pc_nx    = pc + (is_two_word(instr_opcode) ? 16'd2 : 16'd1);
            state_nx = S_OP_WAIT;
          end
        end
      end
      S_HALT:    state_nx = S_HALT;
      default:   state_nx = S_IDLE;
    endcase
    if (redirect_live) begin
      pc_nx    = redirect_addr;
      state_nx = S_OP_WAIT;
    end
  end

  // Memory address and status outputs derived from state and pc.
  always_comb begin
    im_addr     = pc;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (state)
      S_OP_CAP, S_ARG_CAP: im_addr = pc_plus1;
      S_ISSUE:             instr_valid = 1'b1;
      S_HALT:              halted = 1'b1;
      default:             im_addr = pc;
    endcase
  end

  // Instruction capture registers; held stable throughout ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_opcode  <= '0;
      instr_operand <= '0;
      instr_pc      <= '0;
    end else begin
      if (state == S_OP_CAP) begin
        instr_opcode <= im_data;
        instr_pc     <= pc;
        if (!is_two_word(im_data)) instr_operand <= '0;
      end
      if (state == S_ARG_CAP) instr_operand <= im_data;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level fetch model.
module tb_instr_fetch;

  logic        clk;
  logic        rst, start, instr_ready, redirect_valid;
  logic [15:0] redirect_addr, im_addr, im_data;
  logic        instr_valid, halted;
  logic [15:0] instr_opcode, instr_operand, instr_pc;

  logic        rst_b, start_b, ready_b;
  logic [15:0] im_addr_b, im_data_b;
  logic        valid_b, halted_b;
  logic [15:0] opcode_b, operand_b, pc_b;

  logic [15:0] ram  [0:65535];
  logic [15:0] ram2 [0:65535];

  int n_total = 0;
  int n_bad   = 0;
  bit chk_en  = 0;

  instr_fetch #(.RESET_PC(16'd0)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .im_addr(im_addr), .im_data(im_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_operand(instr_operand), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .halted(halted)
  );

  instr_fetch #(.RESET_PC(16'hFFFF)) u_dut_b (
    .clk(clk), .rst(rst_b), .start(start_b),
    .im_addr(im_addr_b), .im_data(im_data_b),
    .instr_valid(valid_b), .instr_ready(ready_b),
    .instr_opcode(opcode_b), .instr_operand(operand_b), .instr_pc(pc_b),
    .redirect_valid(1'b0), .redirect_addr(16'd0),
    .halted(halted_b)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Registered-read instruction memories.
  always @(posedge clk) begin
    im_data   <= ram[im_addr];
    im_data_b <= ram2[im_addr_b];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // An instruction at address p is presented 2 (one-word) or 3 (two-word)
  // cycles after fetching of p begins, and stays until accepted.
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;
  int          m_mode;
  logic [15:0] m_pc;
  int          m_t;
  int          m_acc;

  function automatic bit tw(input logic [15:0] op);
    return op == 16'd6 || op == 16'd8 || op == 16'd29 || op == 16'd31;
  endfunction

  function automatic int lat(input logic [15:0] op);
    return tw(op) ? 3 : 2;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= M_IDLE;
      m_pc   <= 16'd0;
      m_t    <= 0;
      m_acc  <= 0;
    end else if (m_mode == M_IDLE) begin
      if (start) begin
        m_mode <= M_RUN;
        m_t    <= 0;
      end
    end else if (m_mode == M_RUN) begin
      if (m_t >= lat(ram[m_pc]) && instr_ready) m_acc <= m_acc + 1;
      if (redirect_valid) begin
        m_pc <= redirect_addr;
        m_t  <= 0;
      end else if (m_t >= lat(ram[m_pc]) && instr_ready) begin
        if (ram[m_pc] == 16'd43) m_mode <= M_HALT;
        else begin
          m_pc <= m_pc + (tw(ram[m_pc]) ? 16'd2 : 16'd1);
          m_t  <= 0;
        end
      end else begin
        m_t <= m_t + 1;
      end
    end
  end

  // Per-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    logic [15:0] pn, op, ea;
    bit          ev;
    if (chk_en) begin
      pn = m_pc + 16'd1;
      op = ram[m_pc];
      ev = (m_mode == M_RUN) && (m_t >= lat(op));
      ea = m_pc;
      if (m_mode == M_RUN && (m_t == 1 || (m_t == 2 && tw(op)))) ea = pn;
      check("valid", {31'd0, instr_valid}, {31'd0, ev});
      check("im_addr", {16'd0, im_addr}, {16'd0, ea});
      check("halted", {31'd0, halted}, {31'd0, m_mode == M_HALT});
      if (ev) begin
        check("opcode", {16'd0, instr_opcode}, {16'd0, op});
        check("operand", {16'd0, instr_operand}, {16'd0, tw(op) ? ram[pn] : 16'd0});
        check("instr_pc", {16'd0, instr_pc}, {16'd0, m_pc});
      end
    end
  end

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (instr_valid) return;
    end
    check("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic expect_issue(input string name, input logic [15:0] op,
                              input logic [15:0] opnd, input logic [15:0] pc);
    check({name, "_op"}, {16'd0, instr_opcode}, {16'd0, op});
    check({name, "_operand"}, {16'd0, instr_operand}, {16'd0, opnd});
    check({name, "_pc"}, {16'd0, instr_pc}, {16'd0, pc});
  endtask

  logic [15:0] a0;
  bit          seen;

  initial begin
    rst = 1; start = 0; instr_ready = 0; redirect_valid = 0; redirect_addr = '0;
    rst_b = 1; start_b = 0; ready_b = 0;
    for (int i = 0; i < 65536; i++) begin
      ram[i]  = '0;
      ram2[i] = '0;
    end
    ram[0] = 16'd33; ram[1] = 16'd38; ram[2] = 16'd6; ram[3] = 16'd0;
    ram[4] = 16'd33; ram[5] = 16'd31; ram[6] = 16'd216; ram[216] = 16'd43;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk_en = 1;

    // Reset state.
    @(negedge clk);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_im_addr", {16'd0, im_addr}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    expect_issue("rst", 16'd0, 16'd0, 16'd0);

    // Straight-line program, then a stalled LDAC.
    @(posedge clk); #1 start = 1; instr_ready = 1;
    wait_valid(10); expect_issue("i0", 16'd33, 16'd0, 16'd0);
    @(posedge clk); #1;
    wait_valid(10); expect_issue("i1", 16'd38, 16'd0, 16'd1);
    @(posedge clk); #1 instr_ready = 0;
    wait_valid(10); expect_issue("i2", 16'd6, 16'd0, 16'd2);
    a0 = im_addr;
    repeat (4) begin
      @(negedge clk);
      check("stall_valid", {31'd0, instr_valid}, 32'd1);
      expect_issue("stall", 16'd6, 16'd0, 16'd2);
      check("stall_im_addr", {16'd0, im_addr}, {16'd0, a0});
    end
    instr_ready = 1;
    @(negedge clk);
    check("after_ldac_valid", {31'd0, instr_valid}, 32'd0);
    check("after_ldac_im_addr", {16'd0, im_addr}, 32'd4);

    // Taken branch coinciding with acceptance, landing on ENDOP.
    wait_valid(10); expect_issue("i4", 16'd33, 16'd0, 16'd4);
    @(posedge clk); #1;
    wait_valid(10); expect_issue("jppz", 16'd31, 16'd216, 16'd5);
    redirect_valid = 1; redirect_addr = 16'd216;
    @(posedge clk); #1 redirect_valid = 0;
    wait_valid(10); expect_issue("endop", 16'd43, 16'd0, 16'd216);
    @(posedge clk); #1 start = 0;
    @(negedge clk);
    check("halt", {31'd0, halted}, 32'd1);
    check("halt_im_addr", {16'd0, im_addr}, 32'd216);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 start = ~start; redirect_valid = (i == 2); redirect_addr = 16'd7;
      @(negedge clk);
      check("halt_hold", {31'd0, halted}, 32'd1);
      check("halt_hold_valid", {31'd0, instr_valid}, 32'd0);
      check("halt_hold_im_addr", {16'd0, im_addr}, 32'd216);
    end

    // Redirect during opcode capture discards the fetched opcode.
    @(posedge clk); #1 rst = 1; start = 0; redirect_valid = 0; instr_ready = 0;
    ram[100] = 16'd38;
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1 start = 1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (instr_valid) check("early_issue", 32'd1, 32'd0);
      if (im_addr == 16'd1 && !instr_valid) seen = 1;
    end
    check("saw_op_cap", {31'd0, seen}, 32'd1);
    redirect_valid = 1; redirect_addr = 16'd100;
    @(posedge clk); #1 redirect_valid = 0;
    wait_valid(10); expect_issue("redir", 16'd38, 16'd0, 16'd100);

    // Asynchronous reset while an instruction is pending.
    #2 rst = 1;
    #1;
    check("arst_valid", {31'd0, instr_valid}, 32'd0);
    check("arst_im_addr", {16'd0, im_addr}, 32'd0);
    @(posedge clk); #1 rst = 0; start = 0;
    repeat (8) begin
      @(negedge clk);
      check("no_issue_wo_start", {31'd0, instr_valid}, 32'd0);
    end

    // Randomized traffic.
    @(posedge clk); #1 rst = 1;
    for (int i = 0; i < 256; i++) ram[i] = 16'd0;
    for (int i = 0; i < 512; i++) begin
      int unsigned r;
      logic [15:0] a;
      a = (i < 256) ? 16'(i) : 16'(16'hFF00 + (i - 256));
      r = $urandom_range(0, 39);
      case (r % 10)
        0: ram[a] = 16'd6;
        1: ram[a] = 16'd8;
        2: ram[a] = 16'd29;
        3: ram[a] = 16'd31;
        default: ram[a] = 16'($urandom_range(0, 60));
      endcase
      if (ram[a] == 16'd43 && $urandom_range(0, 3) != 0) ram[a] = 16'd1;
    end
    @(posedge clk); #1 rst = 0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      rst            = (m_mode == M_HALT && $urandom_range(0, 4) == 0) || ($urandom_range(0, 299) == 0);
      start          = ($urandom_range(0, 3) == 0);
      instr_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 14) == 0);
      redirect_addr  = ($urandom_range(0, 4) == 0) ? 16'(16'hFFF0 + $urandom_range(0, 15))
                                                   : 16'($urandom_range(0, 255));
    end
    @(posedge clk); #1 rst = 0; start = 0; redirect_valid = 0;
    check("rand_progress", {31'd0, m_acc > 0}, 32'd1);

    // Reset vector at the top of memory with wrapping operand fetch.
    ram2[16'hFFFF] = 16'd6; ram2[0] = 16'd9; ram2[1] = 16'd33;
    @(negedge clk);
    check("b_rst_im_addr", {16'd0, im_addr_b}, 32'h0000FFFF);
    @(posedge clk); #1 rst_b = 0;
    @(posedge clk); #1 start_b = 1; ready_b = 1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (valid_b) seen = 1;
    end
    check("b_valid0", {31'd0, seen}, 32'd1);
    check("b_op0", {16'd0, opcode_b}, 32'd6);
    check("b_operand0", {16'd0, operand_b}, 32'd9);
    check("b_pc0", {16'd0, pc_b}, 32'h0000FFFF);
    @(posedge clk); #1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (valid_b) seen = 1;
    end
    check("b_valid1", {31'd0, seen}, 32'd1);
    check("b_op1", {16'd0, opcode_b}, 32'd33);
    check("b_pc1", {16'd0, pc_b}, 32'd1);

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
